// File: rtl/calc3_port_ingress.sv
// Calc3 per-port ingress: assembles two-cycle requests, validates cmd/tag,
// queues accepted requests for issue and reports rejects as a one-cycle error pulse.
module calc3_port_ingress #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      c_clk,
  input  logic                      reset,
  input  logic [3:0]                req_cmd,
  input  logic [DATA_W-1:0]         req_data,
  input  logic [TAG_W-1:0]          req_tag,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [3:0]                iss_cmd,
  output logic [DATA_W-1:0]         iss_op1,
  output logic [DATA_W-1:0]         iss_op2,
  output logic [TAG_W-1:0]          iss_tag,
  input  logic                      cmpl_valid,
  input  logic [TAG_W-1:0]          cmpl_tag,
  output logic                      err_valid,
  output logic [1:0]                err_resp,
  output logic [TAG_W-1:0]          err_tag,
  output logic [2**TAG_W-1:0]       busy_tags,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NTAG  = 2**TAG_W;

  typedef enum logic {IDLE, OP2} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [DATA_W-1:0]  op1_q, op1_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [3:0]         mem_cmd_q [DEPTH];
  logic [DATA_W-1:0]  mem_op1_q [DEPTH];
  logic [DATA_W-1:0]  mem_op2_q [DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [NTAG-1:0]    busy_q, busy_d;
  logic               err_valid_q, err_valid_d;
  logic [1:0]         err_resp_q, err_resp_d;
  logic [TAG_W-1:0]   err_tag_q, err_tag_d;

  logic cmd_ok, tag_busy, full, pop, push, reject;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (req_cmd != '0) begin
          cmd_d   = req_cmd;
          op1_d   = req_data;
          tag_d   = req_tag;
          state_d = OP2;
        end
      end
      OP2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A completion for the same tag in the OP2 cycle frees it before the busy check.
  assign cmd_ok   = (cmd_q == 4'd1) || (cmd_q == 4'd2) || (cmd_q == 4'd5) || (cmd_q == 4'd6);
  assign tag_busy = busy_q[tag_q] && !(cmpl_valid && (cmpl_tag == tag_q));
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = (count_q != '0) && iss_ready;
  assign push     = (state_q == OP2) && cmd_ok && !tag_busy && !(full && !pop);
  assign reject   = (state_q == OP2) && !push;

  always_comb begin
    busy_d = busy_q;
    if (cmpl_valid) busy_d[cmpl_tag] = 1'b0;
    if (push)       busy_d[tag_q]    = 1'b1;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    err_valid_d = reject;
    err_resp_d  = err_resp_q;
    err_tag_d   = err_tag_q;
    if (reject) begin
      err_resp_d = (!cmd_ok || tag_busy) ? 2'b11 : 2'b10;
      err_tag_d  = tag_q;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      op1_q       <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      err_valid_q <= 1'b0;
      err_resp_q  <= '0;
      err_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      op1_q       <= op1_d;
      tag_q       <= tag_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      err_valid_q <= err_valid_d;
      err_resp_q  <= err_resp_d;
      err_tag_q   <= err_tag_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is reset so the head outputs read zero after reset.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_cmd_q[i] <= '0;
        mem_op1_q[i] <= '0;
        mem_op2_q[i] <= '0;
        mem_tag_q[i] <= '0;
      end
    end else if (push) begin
      mem_cmd_q[wr_ptr_q] <= cmd_q;
      mem_op1_q[wr_ptr_q] <= op1_q;
      mem_op2_q[wr_ptr_q] <= req_data;
      mem_tag_q[wr_ptr_q] <= tag_q;
    end
  end

  assign iss_valid  = (count_q != '0);
  assign iss_cmd    = mem_cmd_q[rd_ptr_q];
  assign iss_op1    = mem_op1_q[rd_ptr_q];
  assign iss_op2    = mem_op2_q[rd_ptr_q];
  assign iss_tag    = mem_tag_q[rd_ptr_q];
  assign err_valid  = err_valid_q;
  assign err_resp   = err_resp_q;
  assign err_tag    = err_tag_q;
  assign busy_tags  = busy_q;
  assign fifo_count = count_q;

endmodule
